// File: rtl/cpu_pkg.sv
// Shared constants and state encoding for the instruction-fetch front end.
package cpu_pkg;

    localparam int CPU_ADDR_W     = 8;
    localparam int CPU_INST_W     = 32;
    localparam int CPU_IMEM_BYTES = 128;
    localparam int CPU_RESET_PC   = 0;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetchState_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: jump beats branch beats sequential, plus legality of the result.
// Stall and flush are resolved by the parent.
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = CPU_ADDR_W,
    parameter int IMEM_BYTES = CPU_IMEM_BYTES
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              jumpTaken,
    input  logic [ADDR_W-1:0] jumpTarget,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchTarget,
    output logic [ADDR_W-1:0] nextPc,
    output logic              redirect,
    output logic              illegal
);

    localparam logic [ADDR_W:0] PC_STEP = (ADDR_W+1)'(4);
    localparam logic [ADDR_W:0] LAST_PC = (ADDR_W+1)'(IMEM_BYTES - 4);

    // One extra bit so a sequential step off the top of the address space
    // is seen as out of range instead of wrapping to a legal low address.
    logic [ADDR_W:0] nextPcWide;

    always_comb begin
        redirect = jumpTaken | branchTaken;
        if (jumpTaken) begin
            nextPcWide = {1'b0, jumpTarget};
        end else if (branchTaken) begin
            nextPcWide = {1'b0, branchTarget};
        end else begin
            nextPcWide = {1'b0, pc} + PC_STEP;
        end
        illegal = (nextPcWide[1:0] != 2'b00) || (nextPcWide > LAST_PC);
        nextPc  = nextPcWide[ADDR_W-1:0];
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, BOOT/RUN/FAULT control and the IF/ID register
// in front of an asynchronous byte-addressed instruction memory.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = CPU_ADDR_W,
    parameter int INST_W     = CPU_INST_W,
    parameter int IMEM_BYTES = CPU_IMEM_BYTES,
    parameter int RESET_PC   = CPU_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchTarget,
    input  logic              jumpTaken,
    input  logic [ADDR_W-1:0] jumpTarget,
    output logic [ADDR_W-1:0] instAddr,
    input  logic [INST_W-1:0] instruction,
    output logic [INST_W-1:0] ifidInst,
    output logic [ADDR_W-1:0] ifidPcPlus4,
    output logic              ifidValid,
    output logic              fault,
    output logic [ADDR_W-1:0] faultAddr
);

    fetchState_t       state, stateNext;
    logic [ADDR_W-1:0] pc, pcNext;
    logic [INST_W-1:0] ifidInstNext;
    logic [ADDR_W-1:0] ifidPcPlus4Next;
    logic              ifidValidNext;
    logic              faultNext;
    logic [ADDR_W-1:0] faultAddrNext;

    logic [ADDR_W-1:0] selPc;
    logic              redirect;
    logic              illegal;
    logic [ADDR_W-1:0] pcPlus4;

    assign instAddr = pc;
    assign pcPlus4  = pc + ADDR_W'(4);

    pc_next_sel #(
        .ADDR_W     (ADDR_W),
        .IMEM_BYTES (IMEM_BYTES)
    ) u_pc_next_sel (
        .pc           (pc),
        .jumpTaken    (jumpTaken),
        .jumpTarget   (jumpTarget),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .nextPc       (selPc),
        .redirect     (redirect),
        .illegal      (illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= ADDR_W'(RESET_PC);
            ifidInst    <= '0;
            ifidPcPlus4 <= '0;
            ifidValid   <= 1'b0;
            fault       <= 1'b0;
            faultAddr   <= '0;
        end else begin
            state       <= stateNext;
            pc          <= pcNext;
            ifidInst    <= ifidInstNext;
            ifidPcPlus4 <= ifidPcPlus4Next;
            ifidValid   <= ifidValidNext;
            fault       <= faultNext;
            faultAddr   <= faultAddrNext;
        end
    end

    always_comb begin
        stateNext       = state;
        pcNext          = pc;
        ifidInstNext    = ifidInst;
        ifidPcPlus4Next = ifidPcPlus4;
        ifidValidNext   = ifidValid;
        faultNext       = fault;
        faultAddrNext   = faultAddr;

        case (state)
            BOOT: begin
                ifidValidNext = 1'b0;
                stateNext     = RUN;
            end
            RUN: begin
                // A redirect acts even under stall, so an illegal target faults through a stall.
                if (redirect || !stall) begin
                    if (illegal) begin
                        stateNext     = FAULT;
                        faultNext     = 1'b1;
                        faultAddrNext = selPc;
                        ifidValidNext = 1'b0;
                    end else if (redirect) begin
                        pcNext        = selPc;
                        ifidValidNext = 1'b0;
                    end else begin
                        pcNext          = selPc;
                        ifidInstNext    = instruction;
                        ifidPcPlus4Next = pcPlus4;
                        ifidValidNext   = ~flush;
                    end
                end
            end
            FAULT: begin
                ifidValidNext = 1'b0;
            end
            default: begin
                stateNext     = FAULT;
                faultNext     = 1'b1;
                ifidValidNext = 1'b0;
            end
        endcase
    end

endmodule
